// File: rtl/board_render_seq.sv
// Walks the 4x4 checkerboard, fetching each cell's occupancy and handing origin/colours
// to the grid drawer over a draw/done handshake, optionally followed by one selector draw.
module board_render_seq #(
  parameter logic [7:0] BOARD_X0   = 8'd31,
  parameter logic [6:0] BOARD_Y0   = 7'd11,
  parameter logic [7:0] CELL_PX    = 8'd25,
  parameter logic [2:0] COL_BLUE   = 3'b001,
  parameter logic [2:0] COL_YELLOW = 3'b110
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       redraw_one,
  input  logic [3:0] cell_sel,
  input  logic       sel_en,
  input  logic [3:0] sel_cell,
  output logic [3:0] cell_addr,
  input  logic [1:0] cell_piece,
  output logic       grid_draw,
  input  logic       grid_done,
  output logic       sel_draw,
  input  logic       sel_done,
  output logic [7:0] start_x,
  output logic [6:0] start_y,
  output logic [2:0] bg_colour,
  output logic [2:0] fg_colour,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, ISSUE, WAIT_G, SEL_ISSUE, WAIT_S, FINISH
  } state_t;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] last_q;
  logic       sel_en_q;
  logic [3:0] sel_cell_q;
  logic [3:0] cell_addr_q;
  logic       grid_draw_q;
  logic       sel_draw_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] bg_q;
  logic [2:0] fg_q;
  logic       busy_q;
  logic       frame_done_q;

  logic [1:0] cell_row;
  logic [1:0] cell_col;
  logic [7:0] cell_x_d;
  logic [6:0] cell_y_d;
  logic [2:0] cell_bg_d;
  logic [2:0] cell_fg_d;
  logic [7:0] sel_x_d;
  logic [6:0] sel_y_d;

  always_comb begin
    cell_row  = idx_q[3:2];
    cell_col  = idx_q[1:0];
    cell_x_d  = BOARD_X0 + CELL_PX * {6'd0, cell_col};
    cell_y_d  = BOARD_Y0 + CELL_PX[6:0] * {5'd0, cell_row};
    // Odd row+col parity is a white square
    cell_bg_d = (cell_row[0] ^ cell_col[0]) ? 3'b111 : 3'b000;
    case (cell_piece)
      2'b01:   cell_fg_d = COL_BLUE;
      2'b10:   cell_fg_d = COL_YELLOW;
      default: cell_fg_d = cell_bg_d;
    endcase
    sel_x_d = BOARD_X0 + CELL_PX * {6'd0, sel_cell_q[1:0]};
    sel_y_d = BOARD_Y0 + CELL_PX[6:0] * {5'd0, sel_cell_q[3:2]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      last_q       <= 4'd0;
      sel_en_q     <= 1'b0;
      sel_cell_q   <= 4'd0;
      cell_addr_q  <= 4'd0;
      grid_draw_q  <= 1'b0;
      sel_draw_q   <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      bg_q         <= 3'd0;
      fg_q         <= 3'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      grid_draw_q  <= 1'b0;
      sel_draw_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || redraw_one) begin
            idx_q       <= start ? 4'd0 : cell_sel;
            last_q      <= start ? 4'd15 : cell_sel;
            cell_addr_q <= start ? 4'd0 : cell_sel;
            sel_en_q    <= sel_en;
            sel_cell_q  <= sel_cell;
            busy_q      <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          // cell_piece is valid now, so the drawer's operands are frozen here
          x_q         <= cell_x_d;
          y_q         <= cell_y_d;
          bg_q        <= cell_bg_d;
          fg_q        <= cell_fg_d;
          grid_draw_q <= 1'b1;
          state_q     <= ISSUE;
        end
        ISSUE: state_q <= WAIT_G;
        WAIT_G: begin
          if (grid_done) begin
            if (idx_q != last_q) begin
              idx_q       <= idx_q + 4'd1;
              cell_addr_q <= idx_q + 4'd1;
              state_q     <= FETCH;
            end else if (sel_en_q) begin
              x_q        <= sel_x_d;
              y_q        <= sel_y_d;
              bg_q       <= COL_YELLOW;
              fg_q       <= COL_YELLOW;
              sel_draw_q <= 1'b1;
              state_q    <= SEL_ISSUE;
            end else begin
              frame_done_q <= 1'b1;
              state_q      <= FINISH;
            end
          end
        end
        SEL_ISSUE: state_q <= WAIT_S;
        WAIT_S: begin
          if (sel_done) begin
            frame_done_q <= 1'b1;
            state_q      <= FINISH;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cell_addr  = cell_addr_q;
  assign grid_draw  = grid_draw_q;
  assign sel_draw   = sel_draw_q;
  assign start_x    = x_q;
  assign start_y    = y_q;
  assign bg_colour  = bg_q;
  assign fg_colour  = fg_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_board_render_seq.sv
// Bench for board_render_seq: a board-store model plus a responsive drawer, with every
// draw compared against a list of expected draws built from the board rules.
module tb_board_render_seq;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       redraw_one = 1'b0;
  logic [3:0] cell_sel = 4'd0;
  logic       sel_en = 1'b0;
  logic [3:0] sel_cell = 4'd0;
  logic [1:0] cell_piece = 2'd0;
  logic       grid_done = 1'b0;
  logic       sel_done = 1'b0;
  logic [3:0] cell_addr;
  logic       grid_draw;
  logic       sel_draw;
  logic [7:0] start_x;
  logic [6:0] start_y;
  logic [2:0] bg_colour;
  logic [2:0] fg_colour;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  board_render_seq dut (
    .clk(clk), .resetn(resetn), .start(start), .redraw_one(redraw_one),
    .cell_sel(cell_sel), .sel_en(sel_en), .sel_cell(sel_cell),
    .cell_addr(cell_addr), .cell_piece(cell_piece),
    .grid_draw(grid_draw), .grid_done(grid_done),
    .sel_draw(sel_draw), .sel_done(sel_done),
    .start_x(start_x), .start_y(start_y),
    .bg_colour(bg_colour), .fg_colour(fg_colour),
    .busy(busy), .frame_done(frame_done)
  );

  // Board-state store with a one-cycle registered read
  logic [1:0] mem [16];
  always @(posedge clk) cell_piece <= mem[cell_addr];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic        is_sel;
    logic [20:0] val;
  } draw_t;
  draw_t exp_q[$];

  function automatic logic [20:0] draw_val(input int c, input bit sel);
    int row, col, x, y, bg, fg;
    row = c / 4;
    col = c % 4;
    x = 31 + 25 * col;
    y = 11 + 25 * row;
    bg = ((row + col) % 2 == 1) ? 7 : 0;
    if (sel) begin
      bg = 6;
      fg = 6;
    end else begin
      case (mem[c])
        2'd1:    fg = 1;
        2'd2:    fg = 6;
        default: fg = bg;
      endcase
    end
    return {x[7:0], y[6:0], bg[2:0], fg[2:0]};
  endfunction

  task automatic run_frame(input bit do_start, input bit do_one, input int csel,
                           input bit sen, input int scell, input int lat, input bit poke);
    draw_t       e;
    logic [20:0] cur, held;
    int          n_exp, n_draw, cnt, first;
    bit          waiting, wait_sel, done;
    exp_q.delete();
    if (do_start) for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, draw_val(c, 1'b0)});
    else if (do_one) exp_q.push_back({1'b0, draw_val(csel, 1'b0)});
    if (sen) exp_q.push_back({1'b1, draw_val(scell, 1'b1)});
    n_exp = exp_q.size();
    n_draw = 0; cnt = 0; first = -1; waiting = 0; wait_sel = 0; done = 0; held = '0;
    @(negedge clk);
    start = do_start; redraw_one = do_one; cell_sel = csel[3:0];
    sel_en = sen; sel_cell = scell[3:0];
    for (int cyc = 1; cyc <= 12000 && !done; cyc++) begin
      @(negedge clk);
      grid_done = 1'b0;
      sel_done = 1'b0;
      if (cyc == 1) begin
        start = 1'b0; redraw_one = 1'b0; sel_en = 1'b0; sel_cell = 4'd0; cell_sel = 4'd0;
        check_eq("busy_on", {31'd0, busy}, 32'd1);
      end
      if (poke && cyc == 30) start = 1'b1;
      if (poke && cyc == 31) start = 1'b0;
      cur = {start_x, start_y, bg_colour, fg_colour};
      if (grid_draw || sel_draw) begin
        n_draw++;
        if (first < 0) begin
          first = cyc;
          check_eq("first_draw_latency", cyc, 3);
        end
        if (exp_q.size() == 0) check_eq("extra_draw", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("draw_kind", {30'd0, grid_draw, sel_draw}, {30'd0, ~e.is_sel, e.is_sel});
          check_eq("draw_val", {11'd0, cur}, {11'd0, e.val});
          $display("draw %0d sel=%0b x=%0d y=%0d bg=%0d fg=%0d", n_draw, sel_draw,
                   start_x, start_y, bg_colour, fg_colour);
        end
        held = cur; cnt = lat; waiting = 1; wait_sel = sel_draw;
      end else if (waiting) begin
        check_eq("hold_val", {11'd0, cur}, {11'd0, held});
        cnt--;
        if (cnt <= 0) begin
          if (wait_sel) sel_done = 1'b1;
          else grid_done = 1'b1;
          waiting = 0;
        end
      end
      if (frame_done) begin
        check_eq("frame_queue_empty", exp_q.size(), 0);
        check_eq("draw_count", n_draw, n_exp);
        done = 1;
      end
    end
    if (!done) check_eq("frame_timeout", 32'd0, 32'd1);
    grid_done = 1'b0;
    sel_done = 1'b0;
    @(negedge clk);
    check_eq("busy_off", {31'd0, busy}, 32'd0);
    check_eq("frame_done_single", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic reset_midway();
    bit seen;
    for (int c = 0; c < 16; c++) mem[c] = 2'($urandom_range(3));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (grid_draw) seen = 1;
    end
    check_eq("rst_draw_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("rst_outputs", {cell_addr, grid_draw, sel_draw, start_x, start_y, bg_colour,
             fg_colour, busy, frame_done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    grid_done = 1'b1;
    sel_done = 1'b1;
    @(negedge clk);
    grid_done = 1'b0;
    sel_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_stray_done", {28'd0, grid_draw, sel_draw, frame_done, busy}, 32'd0);
    end
    $display("reset mid-sequence: outputs cleared, stray done ignored");
  endtask

  initial begin
    int mode, lat;
    for (int c = 0; c < 16; c++) mem[c] = 2'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", {cell_addr, grid_draw, sel_draw, start_x, start_y, bg_colour,
             fg_colour, busy, frame_done}, 32'd0);
    resetn = 1'b1;

    // Empty board, drawer answers 10 cycles after each draw
    run_frame(1'b1, 1'b0, 0, 1'b0, 0, 10, 1'b0);

    // Pieces incl. reserved code; start+redraw_one together and a start while busy
    mem[5] = 2'd1; mem[6] = 2'd2; mem[9] = 2'd3;
    run_frame(1'b1, 1'b1, 7, 1'b0, 0, 3, 1'b1);

    // Single cell plus selector
    for (int c = 0; c < 16; c++) mem[c] = 2'($urandom_range(3));
    run_frame(1'b0, 1'b1, 10, 1'b1, 3, 2, 1'b0);

    // Slow drawer
    run_frame(1'b0, 1'b1, int'($urandom_range(15)), 1'b0, 0, 500, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 16; c++) mem[c] = 2'($urandom_range(3));
      mode = int'($urandom_range(1));
      lat = int'($urandom_range(1, 12));
      run_frame(mode == 1, 1'b1, int'($urandom_range(15)), bit'($urandom_range(1)),
                int'($urandom_range(15)), lat, bit'($urandom_range(1)));
    end

    reset_midway();
    run_frame(1'b0, 1'b1, 15, 1'b1, 0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/board_render_seq.md
Name: board_render_seq

Overview:
Initiator side of the grid-drawer draw/done handshake. It walks the 4x4 checkerboard and reads each cell's occupancy from the board-state store. For every cell it computes origin and colours, pulses draw to the grid drawer and waits for done. After the last cell it can optionally issue one selector-border draw through the same handshake to the selector drawer. It sits between game logic and the two pixel-generating FSMs that feed the VGA adapter.

Parameters:
BOARD_X0, 31, x pixel of board's left edge (8-bit).
BOARD_Y0, 11, y pixel of board's top edge (7-bit).
CELL_PX, 25, cell pitch in pixels.
COL_BLUE, 3'b001, fg colour for blue piece.
COL_YELLOW, 3'b110, fg colour for yellow piece.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
start  in  1  request full-board redraw (sampled in IDLE)
redraw_one  in  1  request redraw of cell_sel only (sampled in IDLE)
cell_sel  in  4  cell for redraw_one, {row[1:0],col[1:0]}
sel_en  in  1  draw selector after cell(s), sampled with the request
sel_cell  in  4  selector cell, sampled with the request
cell_addr  out  4  board-state read address
cell_piece  in  2  occupancy at cell_addr, valid 1 cycle after address: 00 empty, 01 blue, 10 yellow, 11 reserved (=empty)
grid_draw  out  1  1-cycle draw pulse to grid drawer
grid_done  in  1  grid drawer completion pulse
sel_draw  out  1  1-cycle draw pulse to selector drawer
sel_done  in  1  selector drawer completion pulse
start_x  out  8  cell origin x
start_y  out  7  cell origin y
bg_colour  out  3  rim colour
fg_colour  out  3  inner colour
busy  out  1  high from request accept until FINISH exits
frame_done  out  1  1-cycle pulse when sequence completes

Behaviour:
- Reset values (async, resetn=0): state IDLE. grid_draw, sel_draw, busy and frame_done are 0. cell_addr, start_x, start_y, bg_colour and fg_colour are 0.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_G, SEL_ISSUE, WAIT_S, FINISH.
- IDLE:
  - start=1: idx<=0, last<=15, busy<=1, go to FETCH.
  - else redraw_one=1: idx<=cell_sel, last<=cell_sel, busy<=1, go to FETCH.
  - start wins when both are high.
  - sel_en and sel_cell are latched on accept.
- FETCH: cell_addr=idx, then go to LATCH.
- LATCH: capture cell_piece, then go to ISSUE.
- ISSUE: grid_draw=1 for exactly this cycle, then go to WAIT_G.
- Outputs during ISSUE and WAIT_G: start_x, start_y, bg_colour and fg_colour are registered and stable from ISSUE through WAIT_G.
- WAIT_G: hold until grid_done=1. Then:
  - if idx!=last: idx<=idx+1, go to FETCH.
  - else if sel_en was latched: go to SEL_ISSUE.
  - else go to FINISH.
- A grid_done in the same cycle as ISSUE is ignored; the drawer cannot complete that fast.
- SEL_ISSUE: start_x/start_y are the origin of the latched sel_cell. bg_colour = fg_colour = COL_YELLOW. sel_draw=1 for exactly one cycle, then go to WAIT_S.
- WAIT_S: hold until sel_done=1, then go to FINISH.
- FINISH: frame_done=1 for one cycle, busy<=0, go to IDLE.
- Geometry:
  - start_x = BOARD_X0 + col*CELL_PX; start_y = BOARD_Y0 + row*CELL_PX.
  - Compute in 8/7 bits; no overflow for defaults (max 106/86).
- Colouring:
  - (row+col) odd: white square, bg=3'b111. Even: black square, bg=3'b000.
  - fg = bg when empty or reserved; COL_BLUE for 01; COL_YELLOW for 10.
- Requests while busy=1 are ignored; they are not queued.
- idx increments from 15 never wrap, because last=15 terminates the walk.
- Reset mid-sequence aborts immediately to IDLE with all pulses low. A late grid_done/sel_done arriving in IDLE is ignored.
- Latency with an instantly responding drawer: request at edge n gives grid_draw at cycle n+3. Full board = 16 x (4 + drawer time) + 1 cycles.

Test Plan:
- Reset:
  - Stimulus: assert resetn=0 mid-WAIT_G.
  - Response: all outputs 0, state IDLE next cycle; a stray grid_done afterwards causes no pulse.
- Full redraw, empty board:
  - Stimulus: start=1; drawer model returns grid_done 10 cycles after each draw.
  - Response: exactly 16 grid_draw pulses.
  - cell0 gives (31,11) bg/fg 000; cell1 gives (56,11) bg/fg 111; cell15 gives (106,86) bg/fg 000.
  - Then one frame_done, busy=0.
- Pieces:
  - Stimulus: cell_piece 01 at cell 5, 10 at cell 6, 11 at cell 9.
  - Response:
    - cell5 (56,36) bg 000 fg 001.
    - cell6 (81,36) bg 111 fg 110.
    - cell9 (56,61) bg 111 fg 111.
- Single cell plus selector:
  - Stimulus: redraw_one=1, cell_sel=10, sel_en=1, sel_cell=3.
  - Response: one grid_draw at (81,61) bg 000, then one sel_draw at (106,11) colour 110, then frame_done.
- Request arbitration:
  - Stimulus: start and redraw_one together; later, start pulsed while busy.
  - Response: full board drawn once; the second start is ignored (still 16 pulses).
- Slow handshake:
  - Stimulus: grid_done withheld for 500 cycles.
  - Response: grid_draw stays 0 and coords/colours stay stable the whole time; sequence resumes on the done edge.
